mem_io_unit: RTL

MEM_IO_UNIT -- requirements
Module: mem_io_unit

---
 rtl/mem_io_pkg.sv | 56 +++++
 rtl/mem_bram_be.sv | 37 +++
 rtl/mem_io_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_pkg
// Purpose  : Shared encodings and helpers for the memory/IO load-store unit:
//            access sizes, FSM states, IO region select bit, byte-lane enable
//            and load-extension functions.
// Revision : 1.0 - initial release
// ============================================================================
package mem_io_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Address bit that steers a request to the switch/LED region.
  localparam int IO_BASE_BIT = 31;

  // Byte lanes touched by an access of the given size at byte offset off.
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] en;
    en = 4'b0000;
    case (size)
      SZ_BYTE: en = 4'b0001 << off;
      SZ_HALF: en = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Right-align the addressed bytes of a word and sign/zero extend them.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {off, 3'b000};
    res = word;
    case (size)
      SZ_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
      SZ_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage : mem_io_pkg
`default_nettype wire

// File: rtl/mem_bram_be.sv
`default_nettype none
// ============================================================================
// Module   : mem_bram_be
// Purpose  : Single-port 32-bit RAM with per-byte write enables and a
//            registered read port (one cycle latency, read-before-write).
//            Contents are never reset so the array maps onto block RAM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bram_be #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-masked write and registered read on the same enabled cycle.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : mem_bram_be
`default_nettype wire

// File: rtl/mem_io_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_unit
// Purpose  : Load/store unit serving one request at a time from a byte-
//            enabled RAM or from switch/LED channels (addr[31] = 1). Each
//            request runs IDLE -> ACCESS -> RESP with a one-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_unit
  import mem_io_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IO_CH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  input  logic [16*IO_CH-1:0]  sw_in,
  output logic [16*IO_CH-1:0]  led_out
);

  localparam int c_aw = $clog2(DEPTH_WORDS);

  state_e              state_q, state_d;
  logic                we_q, signed_q;
  logic [1:0]          size_q;
  logic [31:0]         addr_q, wdata_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic [16*IO_CH-1:0] sync_q [SYNC_STAGES];

  logic                w_hs, w_is_io, w_ch_bad, w_err, w_commit, w_led_wr, w_ram_en;
  logic [2:0]          w_ch;
  logic [3:0]          w_lanes, w_ram_we;
  logic [31:0]         w_wword, w_ram_rdata, w_src, w_ld;
  logic [c_aw-1:0]     w_ram_addr;
  logic [127:0]        w_sw_pad;
  logic [15:0]         w_sw_ch;

  assign w_hs     = req_valid && (state_q == ST_IDLE) && !rst;
  assign w_is_io  = addr_q[IO_BASE_BIT];
  assign w_ch     = addr_q[4:2];
  assign w_ch_bad = w_is_io && ({1'b0, w_ch} >= 4'(IO_CH));
  assign w_err    = (size_q == SZ_ILL)
                 || ((size_q == SZ_HALF) && addr_q[0])
                 || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
                 || w_ch_bad;
  assign w_lanes  = lane_en(size_q, addr_q[1:0]);
  assign w_wword  = wdata_q << {addr_q[1:0], 3'b000};
  // Stores commit on the ACCESS edge, so a reset on that edge cancels them.
  assign w_commit = (state_q == ST_ACCESS) && !rst && we_q && !w_err;
  assign w_led_wr = w_commit && w_is_io;
  assign w_ram_we = (w_commit && !w_is_io) ? w_lanes : 4'b0000;

  // The read is launched at the handshake so data is ready during ACCESS;
  // the write (if any) uses the captured address one cycle later.
  assign w_ram_addr = (state_q == ST_IDLE) ? req_addr[c_aw+1:2] : addr_q[c_aw+1:2];
  assign w_ram_en   = w_hs || (|w_ram_we);

  mem_bram_be #(
    .DEPTH (DEPTH_WORDS),
    .AW    (c_aw)
  ) u_ram (
    .clk     (clk),
    .en_i    (w_ram_en),
    .we_i    (w_ram_we),
    .addr_i  (w_ram_addr),
    .wdata_i (w_wword),
    .rdata_o (w_ram_rdata)
  );

  // Pad the synchronized switches to 8 channels so the select never overruns.
  assign w_sw_pad = 128'(sync_q[SYNC_STAGES-1]);
  assign w_sw_ch  = w_sw_pad[{w_ch, 4'b0000} +: 16];
  assign w_src    = w_is_io ? {16'h0000, w_sw_ch} : w_ram_rdata;
  assign w_ld     = load_extend(w_src, addr_q[1:0], size_q, signed_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: accept in IDLE, then one ACCESS and one RESP cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Capture the accepted request; later req_* activity is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (w_hs) begin
      we_q     <= req_we;
      signed_q <= req_signed;
      size_q   <= req_size;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
  end

  // Response result, held until the next request reaches RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (state_q == ST_ACCESS) begin
      rsp_err_q   <= w_err;
      rsp_rdata_q <= (we_q || w_err) ? 32'h0 : w_ld;
    end
  end

  // Switch synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  for (genvar c = 0; c < IO_CH; c++) begin : g_led
    logic [15:0] led_q;
    // LED channel: lanes 0/1 of an accepted IO store; lanes 2/3 are dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        led_q <= '0;
      end else if (w_led_wr && (w_ch == 3'(c))) begin
        if (w_lanes[0]) led_q[7:0]  <= w_wword[7:0];
        if (w_lanes[1]) led_q[15:8] <= w_wword[15:8];
      end
    end
    assign led_out[16*c +: 16] = led_q;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule : mem_io_unit
`default_nettype wire
